icache_direct_mapped: RTL and testbench

//   Read-only direct-mapped instruction cache between the pipeline IF stage
//   (ICACHE_* side) and the 128-bit instruction memory. Hits return a word in
//   the same cycle with no stall. Misses stall the fetch and refill one
//   4-word line through a blocking request/ready handshake.

---
 rtl/icache_direct_mapped.sv | 130 +++++++++++++
 tb/tb_icache_direct_mapped.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - read-only direct-mapped instruction cache with blocking line refill
//
// Purpose: sits between the IF stage and a 128-bit instruction memory. Hits
// return a word combinationally with no stall; misses stall the fetch while
// one 4-word line is fetched through a mem_read/mem_ready handshake.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   proc_reset  synchronous active-high reset
//   proc_read   fetch request
//   proc_write  write request (read-only cache: ignored)
//   proc_addr   30-bit word address {tag, index, offset[1:0]}
//   proc_wdata  ignored
//   proc_rdata  fetched word, valid when proc_read && !proc_stall
//   proc_stall  fetch cannot complete this cycle
//   mem_read    line-fetch request (registered)
//   mem_write   always 0
//   mem_addr    28-bit line address {tag, index}
//   mem_rdata   line data, word n at [32n+31:32n]
//   mem_wdata   always 0
//   mem_ready   one-cycle pulse: mem_rdata valid, request done
module icache_direct_mapped #(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = 30 - 2 - IDX_W
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t                state_q;
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];
  logic [27:0]           miss_addr_q;
  logic                  mem_read_q;

  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic [1:0]       addr_off;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [127:0]     line;
  logic             hit;
  logic             unused_inputs;

  assign addr_off = proc_addr[1:0];
  assign addr_idx = proc_addr[IDX_W+1:2];
  assign addr_tag = proc_addr[29:IDX_W+2];
  assign miss_idx = miss_addr_q[IDX_W-1:0];
  assign miss_tag = miss_addr_q[27:IDX_W];

  // The write port of the IF-side interface carries nothing for an icache.
  assign unused_inputs = ^{proc_write, proc_wdata};

  assign hit  = proc_read && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign line = data_q[addr_idx];

  always_comb begin
    proc_rdata = line[{addr_off, 5'b00000} +: 32];
    // Outside IDLE the fetch is always held, whatever the IF stage presents.
    proc_stall = (state_q != IDLE) || (proc_read && !hit);
  end

  assign mem_read  = mem_read_q;
  assign mem_addr  = miss_addr_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (proc_read && !hit) begin
            miss_addr_q <= proc_addr[29:2];
            mem_read_q  <= 1'b1;
            state_q     <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            valid_q[miss_idx] <= 1'b1;
            mem_read_q        <= 1'b0;
            state_q           <= FILL;
          end
        end
        FILL: begin
          // One bubble so the freshly written line is read back on a settled array.
          state_q <= IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; only the valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (!proc_reset && (state_q == FETCH) && mem_ready) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - self-checking bench for icache_direct_mapped
module tb_icache_direct_mapped;

  localparam int IDX_W = 3;
  localparam int NB    = 8;

  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata = '0;
  logic [127:0] mem_wdata;
  logic         mem_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference: which memory line each index currently holds.
  bit         m_valid [NB];
  logic [24:0] m_tag  [NB];

  // Memory responder control.
  int mem_lat = 3;
  int mem_cnt = 0;
  bit spurious = 0;

  icache_direct_mapped dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return ({a, 2'b00} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    return {word_of({la, 2'd3}), word_of({la, 2'd2}), word_of({la, 2'd1}), word_of({la, 2'd0})};
  endfunction

  // Memory: counts cycles of mem_read and pulses mem_ready on the mem_lat-th one.
  always @(posedge clk) begin
    #2;
    if (mem_read) mem_cnt = mem_cnt + 1;
    else          mem_cnt = 0;
    mem_ready = spurious || (mem_read && (mem_cnt == mem_lat));
    mem_rdata = spurious ? {4{32'hBAD0_BAD0}} : line_of(mem_addr);
  end

  function automatic bit model_hit(input logic [29:0] a);
    return m_valid[a[IDX_W+1:2]] && (m_tag[a[IDX_W+1:2]] == a[29:IDX_W+2]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m_valid[i] = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      proc_read = 1'b0;
    end
  endtask

  // One fetch; miss or hit is predicted by the model, latency and data checked.
  task automatic fetch(input logic [29:0] a, input int lat);
    int n;
    bit exp_hit;
    exp_hit = model_hit(a);
    mem_lat = lat;
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = a;
    n = 0;
    #1;
    while (proc_stall && n < 200) begin
      vectors++;
      if (mem_read !== ((n >= 1) && (n <= lat))) begin
        miscompares++;
        $display("FAIL mem_read_phase addr=%h cycle=%0d got=%b", a, n, mem_read);
      end
      if (mem_read) begin
        vectors++;
        if (mem_addr !== a[29:2]) begin
          miscompares++;
          $display("FAIL mem_addr addr=%h got=%h want=%h", a, mem_addr, a[29:2]);
        end
      end
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n != (exp_hit ? 0 : lat + 2)) begin
      miscompares++;
      $display("FAIL stall_cycles addr=%h got=%0d want=%0d", a, n, exp_hit ? 0 : lat + 2);
    end
    vectors++;
    if (proc_rdata !== word_of(a)) begin
      miscompares++;
      $display("FAIL rdata addr=%h got=%h want=%h", a, proc_rdata, word_of(a));
    end
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL mem_read_idle addr=%h got=%b want=0", a, mem_read);
    end
    if (!exp_hit) begin
      m_valid[a[IDX_W+1:2]] = 1;
      m_tag[a[IDX_W+1:2]]   = a[29:IDX_W+2];
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    repeat (3) @(negedge clk);
    proc_reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if ({proc_stall, mem_read, mem_write} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=000", {proc_stall, mem_read, mem_write});
    end
    vectors++;
    if (mem_addr !== 28'd0 || mem_wdata !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_addr mem_addr=%h mem_wdata=%h want 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_cold_miss();
    fetch(30'h5, 3);
  endtask

  task automatic test_hits();
    for (int i = 4; i < 8; i++) fetch(30'(i), 3);
  endtask

  task automatic test_conflict();
    fetch(30'h20, 4);
    fetch(30'h04, 2);
  endtask

  task automatic test_spurious_ready();
    idle(1);
    spurious = 1;
    idle(2);
    spurious = 0;
    fetch(30'h06, 3);
  endtask

  task automatic test_reset_mid_fetch();
    mem_lat = 3;
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h40;
    repeat (3) @(negedge clk);
    // mem_ready is pulsed in this same cycle and must be discarded.
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (mem_read !== 1'b0 || mem_addr !== 28'd0 || proc_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_fetch mem_read=%b mem_addr=%h stall=%b want 0/0/0",
               mem_read, mem_addr, proc_stall);
    end
    fetch(30'h40, 2);
    fetch(30'h04, 2);
  endtask

  task automatic test_write_ignored();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_addr  = 30'h04;
    proc_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({proc_stall, mem_write, mem_read} !== 3'b000 || mem_wdata !== 128'd0) begin
        miscompares++;
        $display("FAIL write_ignored stall/mem_write/mem_read=%b mem_wdata=%h want 000/0",
                 {proc_stall, mem_write, mem_read}, mem_wdata);
      end
      @(negedge clk);
    end
    proc_write = 1'b0;
    fetch(30'h04, 3);
  endtask

  task automatic test_long_latency_addr_change();
    int n;
    logic [29:0] a;
    logic [29:0] b;
    a = 30'h100;
    b = 30'h07;
    mem_lat = 20;
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = a;
    n = 0;
    #1;
    while (proc_stall && n < 200) begin
      if (mem_read) begin
        vectors++;
        if (mem_addr !== a[29:2]) begin
          miscompares++;
          $display("FAIL long_mem_addr cycle=%0d got=%h want=%h", n, mem_addr, a[29:2]);
        end
      end
      @(negedge clk);
      n++;
      if (n == 5)  proc_addr = b;
      if (n == 8)  proc_read = 1'b0;
      if (n == 12) proc_read = 1'b1;
      #1;
    end
    vectors++;
    if (n != 22) begin
      miscompares++;
      $display("FAIL long_stall_cycles got=%0d want=22", n);
    end
    vectors++;
    if (proc_rdata !== word_of(b)) begin
      miscompares++;
      $display("FAIL long_new_addr_rdata got=%h want=%h", proc_rdata, word_of(b));
    end
    m_valid[a[IDX_W+1:2]] = 1;
    m_tag[a[IDX_W+1:2]]   = a[29:IDX_W+2];
    fetch(a, 3);
  endtask

  task automatic test_random();
    logic [29:0] a;
    for (int k = 0; k < 150; k++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      fetch(a, int'($urandom_range(1, 6)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_conflict();
    test_spurious_ready();
    test_reset_mid_fetch();
    test_write_ignored();
    test_long_latency_addr_change();
    test_random();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
